// File: rtl/logic_reduce_unit.sv
// Multi-cycle bitwise reduction engine: folds a stream of operands with
// AND/OR/XOR/NAND and hands back one result over a valid/ready handshake.

module logic_reduce_lane #(
  parameter int VEC_W = 4
) (
  input  logic [1:0]       op,
  input  logic [VEC_W-1:0] acc,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] fold,
  output logic [VEC_W-1:0] fin
);
  // NAND folds as AND; the inversion is applied only to the final value
  always_comb begin
    fold = acc & din;
    case (op)
      2'b01:   fold = acc | din;
      2'b10:   fold = acc ^ din;
      default: fold = acc & din;
    endcase
    fin = (op == 2'b11) ? ~fold : fold;
  end
endmodule

module logic_reduce_unit #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int VEC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err
);
  localparam int NUM_LANES = WIDTH / VEC_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef struct packed {
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
  } cmd_t;

  logic [1:0]                          state;
  cmd_t                                cmd;
  logic [LEN_W-1:0]                    cnt;
  logic [NUM_LANES-1:0][VEC_W-1:0]     acc, fold, fin, din_l, ident;
  logic                                beat, last;

  assign din_l = in_data;
  // OR/XOR start from zero, AND/NAND from all ones
  assign ident = (op[1] ^ op[0]) ? '0 : '1;
  assign beat  = in_valid & in_ready;
  assign last  = beat && (cnt == cmd.len - LEN_W'(1));

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic_reduce_lane #(.VEC_W(VEC_W)) u_lane (
      .op   (cmd.op),
      .acc  (acc[l]),
      .din  (din_l[l]),
      .fold (fold[l]),
      .fin  (fin[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd       <= '0;
      cnt       <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              cmd      <= '{op: op, len: len};
              acc      <= ident;
              cnt      <= '0;
              state    <= ACCUM;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc <= fold;
            cnt <= cnt + LEN_W'(1);
            if (last) begin
              out_data  <= fin;
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_logic_reduce_unit.sv
// Directed bench for logic_reduce_unit; expected values computed by hand.
module tb_logic_reduce_unit;
  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic [1:0] op;
  logic [3:0] len;
  logic [7:0] in_data;
  logic       in_ready, out_valid, busy, err;
  logic [7:0] out_data;
  int vec = 0;
  int errs = 0;

  logic_reduce_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] o, input logic [3:0] l);
    start = 1'b1; op = o; len = l;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; len = 4'd0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    vec++; if (in_ready !== 1'b0)   begin errs++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    vec++; if (out_valid !== 1'b0)  begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vec++; if (out_data !== 8'h00)  begin errs++; $display("FAIL reset_out_data got %h want 00", out_data); end
    vec++; if (busy !== 1'b0)       begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (err !== 1'b0)        begin errs++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_and();
    logic [7:0] b [3] = '{8'hFF, 8'h0F, 8'h3C};
    do_start(2'b00, 4'd3);
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL and_in_ready got %b want 1", in_ready); end
    vec++; if (busy !== 1'b1)     begin errs++; $display("FAIL and_busy got %b want 1", busy); end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = b[i];
      step();
    end
    in_valid = 1'b0;
    vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL and_out_valid got %b want 1", out_valid); end
    vec++; if (out_data !== 8'h0C) begin errs++; $display("FAIL and_out_data got %h want 0c", out_data); end
    vec++; if (in_ready !== 1'b0)  begin errs++; $display("FAIL and_in_ready_drop got %b want 0", in_ready); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL and_handoff_valid got %b want 0", out_valid); end
    vec++; if (busy !== 1'b0)      begin errs++; $display("FAIL and_handoff_busy got %b want 0", busy); end
    vec++; if (out_data !== 8'h0C) begin errs++; $display("FAIL and_hold_data got %h want 0c", out_data); end
  endtask

  task automatic test_xor_gaps();
    logic [7:0] b [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    do_start(2'b10, 4'd4);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = b[i];
      step();
      in_valid = 1'b0; in_data = 8'hFF;
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          step();
          vec++; if (in_ready !== 1'b1)  begin errs++; $display("FAIL xor_gap_ready beat %0d got %b want 1", i, in_ready); end
          vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL xor_gap_valid beat %0d got %b want 0", i, out_valid); end
        end
      end
    end
    vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL xor_out_valid got %b want 1", out_valid); end
    vec++; if (out_data !== 8'h0F) begin errs++; $display("FAIL xor_out_data got %h want 0f", out_data); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_nand_or_hold();
    do_start(2'b11, 4'd1);
    in_valid = 1'b1; in_data = 8'hA5; step(); in_valid = 1'b0;
    vec++; if (out_data !== 8'h5A) begin errs++; $display("FAIL nand_len1 got %h want 5a", out_data); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    do_start(2'b01, 4'd2);
    in_valid = 1'b1; in_data = 8'h00; step(); step(); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL or_hold_valid cyc %0d got %b want 1", i, out_valid); end
      vec++; if (out_data !== 8'h00) begin errs++; $display("FAIL or_hold_data cyc %0d got %h want 00", i, out_data); end
      step();
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL or_drain_busy got %b want 0", busy); end
  endtask

  task automatic test_err_ignore();
    do_start(2'b00, 4'd0);
    vec++; if (err !== 1'b1)      begin errs++; $display("FAIL err_pulse got %b want 1", err); end
    vec++; if (busy !== 1'b0)     begin errs++; $display("FAIL err_busy got %b want 0", busy); end
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL err_in_ready got %b want 0", in_ready); end
    step();
    vec++; if (err !== 1'b0)      begin errs++; $display("FAIL err_one_cycle got %b want 0", err); end
    do_start(2'b00, 4'd2);
    start = 1'b1; op = 2'b01; len = 4'd5;
    in_valid = 1'b1; in_data = 8'hF0; step(); in_data = 8'h3C; step(); in_valid = 1'b0;
    vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL ign_out_valid got %b want 1", out_valid); end
    vec++; if (out_data !== 8'h30) begin errs++; $display("FAIL ign_out_data got %h want 30", out_data); end
    out_ready = 1'b1; step(); out_ready = 1'b0; start = 1'b0;
    step();
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL ign_done_start busy got %b want 0", busy); end
  endtask

  task automatic test_abort();
    do_start(2'b00, 4'd5);
    in_valid = 1'b1; in_data = 8'h00; step(); step(); in_valid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    vec++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0)
      begin errs++; $display("FAIL abort_ctrl got busy=%b rdy=%b vld=%b err=%b want 0000", busy, in_ready, out_valid, err); end
    vec++; if (out_data !== 8'h00) begin errs++; $display("FAIL abort_data got %h want 00", out_data); end
    do_start(2'b01, 4'd2);
    in_valid = 1'b1; in_data = 8'h80; step(); in_data = 8'h01; step(); in_valid = 1'b0;
    vec++; if (out_data !== 8'h81) begin errs++; $display("FAIL abort_rerun got %h want 81", out_data); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_len15();
    do_start(2'b10, 4'd15);
    in_valid = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      in_data = 8'(i);
      step();
      if (i == 14) begin
        vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
          begin errs++; $display("FAIL len15_beat14 got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
      end
    end
    in_valid = 1'b0;
    vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL len15_valid got %b want 1", out_valid); end
    vec++; if (out_data !== 8'h00) begin errs++; $display("FAIL len15_data got %h want 00", out_data); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    do_start(2'b01, 4'd2);
    in_valid = 1'b1; in_data = 8'h11; step(); in_data = 8'h22; step(); in_valid = 1'b0;
    vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid got %b want 1", out_valid); end
    step();
    vec++; if (busy !== 1'b0)      begin errs++; $display("FAIL b2b_turnaround busy got %b want 0", busy); end
    vec++; if (out_data !== 8'h33) begin errs++; $display("FAIL b2b_data got %h want 33", out_data); end
    do_start(2'b00, 4'd1);
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_restart busy got %b want 1", busy); end
    in_valid = 1'b1; in_data = 8'h0F; step(); in_valid = 1'b0;
    vec++; if (out_data !== 8'h0F) begin errs++; $display("FAIL b2b_second got %h want 0f", out_data); end
    step();
    out_ready = 1'b0;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_end_valid got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_and();
    test_xor_gaps();
    test_nand_or_hold();
    test_err_ignore();
    test_abort();
    test_len15();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
